flexdpe_sched: RTL

Job sequencer for one FLEX-DPE macro PE. It takes one job command, pulls one stationary vector and then N streaming vectors from an upstream vector buffer over a valid/ready handshake. It drives the FLEX-DPE `i_data_valid` / `i_stationary` controls. It then holds busy for a fixed drain window covering the xbar, multiplier and FAN reduction pipeline, and pulses done when the window ends. Data and destination buses bypass this block; it only gates when a vector is accepted and how that vector is tagged.

---
 rtl/flexdpe_sched.sv | 130 +++++++++++++
 1 files changed

// File: rtl/flexdpe_sched.sv
// flexdpe_sched: job sequencer for a single FLEX-DPE macro PE.
// A job loads one stationary vector and then N streaming vectors over a
// valid/ready handshake. It then waits a fixed drain window for the PE
// pipeline to empty, and pulses done when the window ends. Only the
// handshake and the vector tagging are produced here. Data and destination
// buses bypass this block.
module flexdpe_sched #(
  parameter int LOG2_STREAM  = 8,
  parameter int DRAIN_CYCLES = 12
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [LOG2_STREAM-1:0] i_num_stream,
  input  logic                   i_abort,
  input  logic                   i_src_valid,
  output logic                   o_src_ready,
  output logic                   o_dpe_valid,
  output logic                   o_dpe_stationary,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [LOG2_STREAM-1:0] o_vec_cnt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_STAT = 3'd1,
    STREAM    = 3'd2,
    DRAIN     = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [LOG2_STREAM-1:0] CNT_ZERO   = {LOG2_STREAM{1'b0}};
  localparam logic [LOG2_STREAM-1:0] CNT_ONE    = {{(LOG2_STREAM-1){1'b0}}, 1'b1};
  localparam logic [7:0]             DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

  state_t                 state;
  state_t                 state_next;
  logic [LOG2_STREAM-1:0] remaining;
  logic [LOG2_STREAM-1:0] vec_cnt;
  logic [7:0]             drain_cnt;
  logic                   src_ready;
  logic                   xfer;

  // State register. Reset drops any job in flight without a done pulse.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Abort overrides every other transition outside IDLE.
  always_comb begin
    state_next = state;
    if ((state != IDLE) && i_abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) state_next = LOAD_STAT;
          else         state_next = IDLE;
        end
        LOAD_STAT: begin
          if (xfer) begin
            if (remaining == CNT_ZERO) state_next = DRAIN;
            else                       state_next = STREAM;
          end else begin
            state_next = LOAD_STAT;
          end
        end
        STREAM: begin
          if (xfer && (remaining == CNT_ONE)) state_next = DRAIN;
          else                                state_next = STREAM;
        end
        DRAIN: begin
          if (drain_cnt == 8'd0) state_next = DONE;
          else                   state_next = DRAIN;
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode. Only i_src_valid reaches an output without a register.
  always_comb begin
    src_ready        = (state == LOAD_STAT) || (state == STREAM);
    xfer             = src_ready && i_src_valid;
    o_src_ready      = src_ready;
    o_dpe_valid      = xfer;
    o_dpe_stationary = xfer && (state == LOAD_STAT);
    o_busy           = (state != IDLE);
    o_done           = (state == DONE);
    o_vec_cnt        = vec_cnt;
  end

  // Job counters. The remaining count is latched on start and consumed by
  // streaming transfers. vec_cnt is kept after the job ends or is aborted.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      remaining <= CNT_ZERO;
      vec_cnt   <= CNT_ZERO;
    end else if ((state == IDLE) && i_start) begin
      remaining <= i_num_stream;
      vec_cnt   <= CNT_ZERO;
    end else if ((state == STREAM) && xfer) begin
      remaining <= remaining - CNT_ONE;
      vec_cnt   <= vec_cnt + CNT_ONE;
    end else begin
      remaining <= remaining;
      vec_cnt   <= vec_cnt;
    end
  end

  // Drain window counter. It is loaded on entry to DRAIN and counts down to zero.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      drain_cnt <= 8'd0;
    end else if ((state_next == DRAIN) && (state != DRAIN)) begin
      drain_cnt <= DRAIN_LOAD;
    end else if ((state == DRAIN) && (drain_cnt != 8'd0)) begin
      drain_cnt <= drain_cnt - 8'd1;
    end else begin
      drain_cnt <= drain_cnt;
    end
  end

endmodule
